// File: rtl/run_before_decoder.sv
// H.264 CAVLC run_before decoder: one code per cycle from a peek window.
// Produces the 16-entry run list for one block, with stall and error handling.
module run_before_decoder #(
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             h264_reset,
  input  logic             dec_start,
  input  logic [4:0]       total_coeff,
  input  logic [4:0]       total_zero_cnt,
  input  logic [WIN_W-1:0] bs_window,
  input  logic             bs_valid,
  output logic             bs_consume,
  output logic [3:0]       bs_len,
  output logic [4:0]       runbefore_list [0:15],
  output logic             busy,
  output logic             dec_done,
  output logic             dec_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_FINISH
  } state_t;

  state_t     r_state;
  logic [4:0] r_list [0:15];
  logic [3:0] r_idx;
  logic [4:0] r_zl;
  logic [4:0] r_cnt;
  logic       r_err;

  logic [10:0] w_b11;
  logic [2:0]  w_t3;
  logic [3:0]  w_lz;
  logic [4:0]  w_run;
  logic [3:0]  w_len;
  logic        w_bad;
  logic        w_stop;
  logic        w_last;
  logic        w_go;

  assign w_b11 = bs_window[WIN_W-1 -: 11];
  assign w_t3  = w_b11[10:8];

  if (WIN_W > 11) begin : g_tail
    logic w_unused;
    assign w_unused = ^bs_window[WIN_W-12:0];
  end

  // Leading-zero count over the 11-bit peek; 11 means no 1 seen.
  always_comb begin
    w_lz = 4'd11;
    for (int i = 0; i < 11; i++)
      if (w_b11[i]) w_lz = 4'(10 - i);
  end

  always_comb begin
    w_run = '0;
    w_len = '0;
    unique case (1'b1)
      (r_zl == 5'd1): begin
        w_run = {4'd0, ~w_t3[2]};
        w_len = 4'd1;
      end
      (r_zl == 5'd2): begin
        if (w_t3[2]) begin
          w_len = 4'd1;
        end else begin
          w_run = w_t3[1] ? 5'd1 : 5'd2;
          w_len = 4'd2;
        end
      end
      (r_zl == 5'd3): begin
        w_run = 5'd3 - {3'd0, w_t3[2:1]};
        w_len = 4'd2;
      end
      (r_zl == 5'd4): begin
        if (|w_t3[2:1]) begin
          w_run = 5'd3 - {3'd0, w_t3[2:1]};
          w_len = 4'd2;
        end else begin
          w_run = w_t3[0] ? 5'd3 : 5'd4;
          w_len = 4'd3;
        end
      end
      (r_zl == 5'd5): begin
        if (w_t3[2]) begin
          w_run = w_t3[1] ? 5'd0 : 5'd1;
          w_len = 4'd2;
        end else begin
          w_run = 5'd5 - {3'd0, w_t3[1:0]};
          w_len = 4'd3;
        end
      end
      (r_zl == 5'd6): begin
        w_len = 4'd3;
        unique case (w_t3)
          3'b110,
          3'b111: begin
            w_run = 5'd0;
            w_len = 4'd2;
          end
          3'b000: w_run = 5'd1;
          3'b001: w_run = 5'd2;
          3'b011: w_run = 5'd3;
          3'b010: w_run = 5'd4;
          3'b101: w_run = 5'd5;
          3'b100: w_run = 5'd6;
        endcase
      end
      (r_zl > 5'd6): begin
        if (w_lz < 4'd3) begin
          w_run = 5'd7 - {2'd0, w_t3};
          w_len = 4'd3;
        end else begin
          w_run = {1'b0, w_lz} + 5'd4;
          w_len = w_lz + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign w_bad  = ((r_zl > 5'd6) && (w_lz == 4'd11)) ||
                  (w_run > r_zl);
  assign w_stop = r_err || (r_cnt == 5'd0);
  assign w_last = (r_zl == 5'd0) ||
                  ({1'b0, r_idx} == r_cnt - 5'd1);
  assign w_go   = (r_state == S_DECODE) && !w_stop &&
                  !w_last && bs_valid && !w_bad;

  assign bs_consume     = w_go;
  assign bs_len         = w_go ? w_len : 4'd0;
  assign busy           = (r_state != S_IDLE);
  assign dec_done       = (r_state == S_FINISH);
  assign dec_err        = dec_done && r_err;
  assign runbefore_list = r_list;

  always_ff @(posedge clk) begin
    if (!rst || h264_reset) begin
      r_state <= S_IDLE;
      for (int k = 0; k < 16; k++) r_list[k] <= '0;
      r_idx <= '0;
      r_zl  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (dec_start) begin
            for (int k = 0; k < 16; k++) r_list[k] <= '0;
            r_idx   <= '0;
            r_zl    <= total_zero_cnt;
            r_cnt   <= total_coeff;
            r_err   <= (total_coeff > 5'd16) ||
                       (total_zero_cnt > 5'd15);
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_stop) begin
            r_state <= S_FINISH;
          end else if (w_last) begin
            r_list[r_idx] <= r_zl;
            r_state       <= S_FINISH;
          end else if (bs_valid) begin
            if (w_bad) begin
              r_err   <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_list[r_idx] <= w_run;
              r_zl          <= r_zl - w_run;
              r_idx         <= r_idx + 4'd1;
            end
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule
